// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package divider_arbiter_pkg;

  localparam int unsigned DIV_LATENCY = 17;
  localparam int unsigned DIVIDEND_W  = 8;
  localparam int unsigned DIVISOR_W   = 7;
  localparam int unsigned CNT_W       = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Remainder reported for a divide-by-zero bypass: the dividend truncated to the remainder width.
  function automatic logic [DIVISOR_W-1:0] bypass_rem(input logic [DIVIDEND_W-1:0] dividend);
    return dividend[DIVISOR_W-1:0];
  endfunction

endpackage

// File: rtl/divider_arbiter_if.sv
// Requester and shared-divider signals of divider_arbiter, bundled with one modport per side.
interface divider_arbiter_if;

  logic                                     req0;
  logic                                     req1;
  logic [divider_arbiter_pkg::DIVIDEND_W-1:0] dividend0;
  logic [divider_arbiter_pkg::DIVIDEND_W-1:0] dividend1;
  logic [divider_arbiter_pkg::DIVISOR_W-1:0]  divisor0;
  logic [divider_arbiter_pkg::DIVISOR_W-1:0]  divisor1;
  logic                                     done0;
  logic                                     done1;
  logic [divider_arbiter_pkg::DIVIDEND_W-1:0] quotient_o;
  logic [divider_arbiter_pkg::DIVISOR_W-1:0]  remainder_o;
  logic                                     err_o;
  logic                                     busy;
  logic                                     div_start;
  logic [divider_arbiter_pkg::DIVIDEND_W-1:0] div_dividend;
  logic [divider_arbiter_pkg::DIVISOR_W-1:0]  div_divisor;
  logic [divider_arbiter_pkg::DIVIDEND_W-1:0] div_quotient;
  logic [divider_arbiter_pkg::DIVISOR_W-1:0]  div_remainder;
  logic                                     div_valid;

  modport slave (
    input  req0, req1, dividend0, dividend1, divisor0, divisor1,
    input  div_quotient, div_remainder, div_valid,
    output done0, done1, quotient_o, remainder_o, err_o, busy,
    output div_start, div_dividend, div_divisor
  );

  modport master (
    output req0, req1, dividend0, dividend1, divisor0, divisor1,
    output div_quotient, div_remainder, div_valid,
    input  done0, done1, quotient_o, remainder_o, err_o, busy,
    input  div_start, div_dividend, div_divisor
  );

endinterface

// File: rtl/divider_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Arbitrates two requesters onto one fixed-latency divider and returns the result to the owner.
// Optional feature: define DIVZERO_BYPASS_EN to answer divide-by-zero directly with err_o set.
module divider_arbiter
  import divider_arbiter_pkg::*;
(
  input logic               clk,
  input logic               reset,
  divider_arbiter_if.slave  bus
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic [DIVIDEND_W-1:0]   a_q, a_d;
  logic [DIVISOR_W-1:0]    b_q, b_d;
  logic [DIVIDEND_W-1:0]   quot_q, quot_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
`ifdef DIVZERO_BYPASS_EN
  logic                    err_q, err_d;
`endif

  logic [1:0]              req;
  logic [1:0]              gnt;
  logic [DIVIDEND_W-1:0]   sel_dividend;
  logic [DIVISOR_W-1:0]    sel_divisor;
  logic                    unused_div_valid;

  assign unused_div_valid = bus.div_valid;
  assign req              = {bus.req1, bus.req0};
  assign sel_dividend     = gnt[1] ? bus.dividend1 : bus.dividend0;
  assign sel_divisor      = gnt[1] ? bus.divisor1  : bus.divisor0;

  rr_arb2 u_rr_arb2 (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVZERO_BYPASS_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      // The DONE cycle arbitrates like IDLE so a held request is re-granted without a gap.
      StIdle, StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
        if (|req) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          a_d     = sel_dividend;
          b_d     = sel_divisor;
          state_d = StStart;
`ifdef DIVZERO_BYPASS_EN
          if (sel_divisor == '0) begin
            state_d = StDone;
            quot_d  = '1;
            rem_d   = bypass_rem(sel_dividend);
            err_d   = 1'b1;
          end
`endif
        end
      end
      StStart: begin
        state_d = StWait;
        cnt_d   = CNT_W'(1);
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_LATENCY)) begin
          quot_d  = bus.div_quotient;
          rem_d   = bus.div_remainder;
`ifdef DIVZERO_BYPASS_EN
          err_d   = 1'b0;
`endif
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIVZERO_BYPASS_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIVZERO_BYPASS_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.div_start    = (state_q == StStart);
  assign bus.done0        = (state_q == StDone) & ~owner_q;
  assign bus.done1        = (state_q == StDone) &  owner_q;
  assign bus.div_dividend = bus.busy ? a_q : '0;
  assign bus.div_divisor  = bus.busy ? b_q : '0;
  assign bus.quotient_o   = quot_q;
  assign bus.remainder_o  = rem_q;
`ifdef DIVZERO_BYPASS_EN
  assign bus.err_o        = err_q;
`else
  assign bus.err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_divider_arbiter;
  import divider_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   starts = 0;
  int   dcnt = 31;

  divider_arbiter_if bus ();

  divider_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (reset && bus.div_start) starts = starts + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Divider stand-in: the true result appears only in the cycle the arbiter must capture it.
  always @(negedge clk) begin
    if (bus.div_start) dcnt = 0;
    else if (dcnt < 31) dcnt = dcnt + 1;
    bus.div_valid = 1'($urandom);
    if (dcnt == int'(DIV_LATENCY) && bus.div_divisor != 0) begin
      bus.div_quotient  = bus.div_dividend / bus.div_divisor;
      bus.div_remainder = 7'(bus.div_dividend % bus.div_divisor);
    end else begin
      bus.div_quotient  = 8'($urandom);
      bus.div_remainder = 7'($urandom);
    end
  end

  // Timeline model: m_t counts edges since the grant; 0 is the start cycle, 18 the done cycle.
  bit m_busy, m_owner, m_last;
  int m_t, m_a, m_b, m_q, m_r, m_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_t = 0;
      m_a = 0; m_b = 0; m_q = 0; m_r = 0; m_err = 0;
    end else if (m_busy && m_t < 18) begin
      m_t = m_t + 1;
      if (m_t == 18) begin
        m_q = (m_b != 0) ? m_a / m_b : 255;
        m_r = (m_b != 0) ? m_a % m_b : m_a % 128;
        m_err = 0;
      end
    end else if (bus.req0 || bus.req1) begin
      m_owner = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      m_last  = m_owner;
      m_a     = m_owner ? int'(bus.dividend1) : int'(bus.dividend0);
      m_b     = m_owner ? int'(bus.divisor1)  : int'(bus.divisor0);
      m_busy  = 1;
      m_t     = 0;
`ifdef DIVZERO_BYPASS_EN
      if (m_b == 0) begin
        m_t = 18; m_q = 255; m_r = m_a % 128; m_err = 1;
      end
`endif
    end else begin
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("busy", bus.busy, m_busy);
      chk("div_start", bus.div_start, m_busy && m_t == 0);
      chk("done0", bus.done0, m_busy && m_t == 18 && !m_owner);
      chk("done1", bus.done1, m_busy && m_t == 18 && m_owner);
      chk("quotient_o", bus.quotient_o, m_q);
      chk("remainder_o", bus.remainder_o, m_r);
      chk("err_o", bus.err_o, m_err);
      chk("div_dividend", bus.div_dividend, m_busy ? m_a : 0);
      chk("div_divisor", bus.div_divisor, m_busy ? m_b : 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done0 | bus.done1, 0);
    chk({tag, "_start"}, bus.div_start, 0);
    chk({tag, "_quot"}, bus.quotient_o, 0);
    chk({tag, "_rem"}, bus.remainder_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_ops"}, bus.div_dividend | 8'(bus.div_divisor), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req0 = 0; bus.req1 = 0;
    reset = 0;
    #1 check_reset_outputs("rst");
    @(negedge clk);
    reset = 1;
  endtask

  task automatic wait_done(input int idx, output int at);
    at = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if ((idx == 0 && bus.done0) || (idx == 1 && bus.done1)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL done%0d_timeout actual=none required=pulse", idx);
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 100 && cyc < target; k++) @(negedge clk);
  endtask

  function automatic int rnd_div();
`ifdef DIVZERO_BYPASS_EN
    if ($urandom % 8 == 0) return 0;
`endif
    return int'($urandom_range(127, 1));
  endfunction

  task automatic drive_rand();
    logic d0, d1;
    d0 = bus.done0;
    d1 = bus.done1;
    if (d0) bus.req0 = ($urandom % 3 == 0);
    else if (!bus.req0) bus.req0 = ($urandom % 6 == 0);
    else if ($urandom % 80 == 0) bus.req0 = 0;
    if (d1) bus.req1 = ($urandom % 3 == 0);
    else if (!bus.req1) bus.req1 = ($urandom % 6 == 0);
    else if ($urandom % 80 == 0) bus.req1 = 0;
    if ($urandom % 4 == 0) begin
      bus.dividend0 = 8'($urandom);
      bus.divisor0  = 7'(rnd_div());
    end
    if ($urandom % 4 == 0) begin
      bus.dividend1 = 8'($urandom);
      bus.divisor1  = 7'(rnd_div());
    end
  endtask

  initial begin
    int g, at, n;
    bus.req0 = 0; bus.req1 = 0;
    bus.dividend0 = 0; bus.dividend1 = 0;
    bus.divisor0 = 1; bus.divisor1 = 1;
    bus.div_quotient = 0; bus.div_remainder = 0; bus.div_valid = 0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1;

    // Single request 200/7.
    @(negedge clk);
    starts = 0;
    bus.req0 = 1; bus.dividend0 = 200; bus.divisor0 = 7;
    g = cyc + 1;
    wait_done(0, at);
    chk("t1_latency", at - g + 1, 19);
    chk("t1_quot", bus.quotient_o, 28);
    chk("t1_rem", bus.remainder_o, 4);
    bus.req0 = 0;
    chk("t1_starts", starts, 1);

    // Contention after reset: requester 0 first, then requester 1.
    do_reset();
    bus.req0 = 1; bus.dividend0 = 255; bus.divisor0 = 127;
    bus.req1 = 1; bus.dividend1 = 100; bus.divisor1 = 10;
    g = cyc + 1;
    wait_done(0, at);
    chk("t2_done0_at", at - g, 18);
    chk("t2_quot0", bus.quotient_o, 2);
    chk("t2_rem0", bus.remainder_o, 1);
    bus.req0 = 0;
    wait_done(1, at);
    chk("t2_done1_at", at - g, 19 + 18);
    chk("t2_quot1", bus.quotient_o, 10);
    chk("t2_rem1", bus.remainder_o, 0);
    bus.req1 = 0;

    // Requester 1 holds its request: back-to-back service every 19 cycles.
    do_reset();
    bus.req1 = 1; bus.dividend1 = 50; bus.divisor1 = 3;
    g = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      wait_done(1, at);
      chk("t3_done1_at", at - g, 18 + 19 * i);
      chk("t3_quot", bus.quotient_o, 16);
      chk("t3_rem", bus.remainder_o, 2);
    end
    bus.req1 = 0;

    // Reset during wait cycle 9 aborts the operation.
    @(negedge clk);
    bus.req0 = 1; bus.dividend0 = 13; bus.divisor0 = 100;
    g = cyc + 1;
    wait_cyc(g + 9);
    chk("t4_busy_pre", bus.busy, 1);
    chk("t4_quot_hold", bus.quotient_o, 16);
    #1 reset = 0; bus.req0 = 0;
    #1 check_reset_outputs("t4");
    @(negedge clk);
    reset = 1;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) n = n + 1;
    end
    chk("t4_no_done", n, 0);
    bus.req0 = 1;
    g = cyc + 1;
    wait_done(0, at);
    chk("t4_latency", at - g + 1, 19);
    chk("t4_quot", bus.quotient_o, 0);
    chk("t4_rem", bus.remainder_o, 13);
    bus.req0 = 0;

    // Operands changed during wait cycle 3 must not matter.
    @(negedge clk);
    bus.req0 = 1; bus.dividend0 = 200; bus.divisor0 = 7;
    g = cyc + 1;
    wait_cyc(g + 3);
    bus.dividend0 = 13; bus.divisor0 = 100;
    wait_done(0, at);
    chk("t5_quot", bus.quotient_o, 28);
    chk("t5_rem", bus.remainder_o, 4);
    bus.req0 = 0;

`ifdef DIVZERO_BYPASS_EN
    do_reset();
    starts = 0;
    bus.req0 = 1; bus.dividend0 = 45; bus.divisor0 = 0;
    g = cyc + 1;
    wait_done(0, at);
    chk("t6_latency", at - g + 1, 1);
    chk("t6_err", bus.err_o, 1);
    chk("t6_quot", bus.quotient_o, 255);
    chk("t6_rem", bus.remainder_o, 45);
    bus.req0 = 0;
    repeat (3) @(negedge clk);
    chk("t6_starts", starts, 0);
`endif

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom % 500 == 0) begin
        bus.req0 = 0; bus.req1 = 0;
        reset = 0;
        #2 reset = 1;
      end else begin
        drive_rand();
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (25) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req0, req1  input  1 each  level request, held until the matching done pulse.
REQ-004 SHALL have ports: dividend0, dividend1  input  8 each; divisor0, divisor1  input  7 each  requester operands.
REQ-005 SHALL have ports: done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-006 SHALL have ports: quotient_o  output  8; remainder_o  output  7  shared result bus, meaningful while a done pulse is high.
REQ-007 SHALL have ports: err_o  output  1  divide-by-zero flag, valid with done; busy  output  1  high in every state except IDLE.
REQ-008 SHALL have ports: div_start  output  1; div_dividend  output  8; div_divisor  output  7  drive the shared divider.
REQ-009 SHALL have ports: div_quotient  input  8; div_remainder  input  7; div_valid  input  1  divider results; div_valid is ignored.

Function
REQ-010 SHALL implement the states IDLE, START, WAIT and DONE.
REQ-011 In IDLE, at an edge (E0) where any req is high, SHALL grant one requester, latch its operands and owner id, and go to START.
REQ-012 Arbitration SHALL be two-way round-robin: when both requests are high, grant the one not granted last; after reset requester 0 wins.
REQ-013 In START, SHALL assert div_start=1 for exactly one cycle, then go to WAIT with cnt=1.
REQ-014 In WAIT, SHALL hold div_start=0, drive the latched operands constantly on div_dividend/div_divisor, and increment cnt each cycle.
REQ-015 At the edge ending WAIT cycle 17 (E18), SHALL capture div_quotient and div_remainder into result registers and go to DONE.
REQ-016 In DONE (the cycle after E18), SHALL pulse done of the owner for exactly one cycle, then go to IDLE at E19.
REQ-017 Request-to-done latency SHALL be exactly 19 cycles; the earliest next grant is at E19.
REQ-018 quotient_o and remainder_o SHALL hold the last captured values until the next capture.
REQ-019 Operands SHALL be sampled only at the grant edge; operand changes after grant SHALL have no effect.
REQ-020 If the owner drops req mid-operation, the operation SHALL still complete and done SHALL still pulse.
REQ-021 A req still high in the DONE cycle SHALL be treated as a new request in IDLE.
REQ-022 div_dividend and div_divisor SHALL be 0 in IDLE.

Reset
REQ-023 Asserting reset (low) SHALL asynchronously force state IDLE, cnt=0, the round-robin pointer to "last granted = 1", and all outputs to 0, including mid-operation.
REQ-024 An operation aborted by reset SHALL produce no done pulse, and after deassertion the block SHALL re-arbitrate from scratch.

Configuration
REQ-025 With DIVZERO_BYPASS_EN defined, a granted request with divisor=0 SHALL skip START/WAIT and go directly to DONE.
REQ-026 In that bypass case: div_start SHALL stay 0, quotient_o=8'hFF, remainder_o=dividend[6:0], err_o=1, and done SHALL pulse in the cycle after the grant.
REQ-027 Without DIVZERO_BYPASS_EN, a zero divisor SHALL be forwarded normally (result undefined) and err_o SHALL be tied to 0.

Structure
REQ-028 Package divider_arbiter_pkg SHALL hold the state enum, DIV_LATENCY=17, DIVIDEND_W=8 and DIVISOR_W=7.
REQ-029 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant (inputs: req[1:0], pointer; outputs: one-hot grant) and is the only sub-module.

Verification
REQ-030 SHALL cover: req0 only, 200/7 -> done0 exactly 19 cycles after the grant edge, quotient_o=28, remainder_o=4, one div_start pulse.
REQ-031 SHALL cover: req0 and req1 both high, 255/127 and 100/10 -> req0 served first (2 rem 1), then req1 with done1 at E19+19 (10 rem 0).
REQ-032 SHALL cover: req1 holds req through its done while req0 is idle -> back-to-back grants to req1, with done1 every 19 cycles.
REQ-033 SHALL cover: reset asserted in WAIT cycle 9 of 13/100 -> outputs 0 immediately, no done; re-request yields 0 rem 13.
REQ-034 SHALL cover: operands changed in cycle 3 of WAIT for 200/7 -> result still 28 rem 4.
REQ-035 SHALL cover, with DIVZERO_BYPASS_EN: 45/0 -> done at E1, err_o=1, quotient_o=255, remainder_o=45, div_start never high.
